// File: rtl/peak_find_frame_if.sv
// ---------------------------------------------------------------------------
// peak_find_frame_if
// Groups the read-path beat stream and the frame-result outputs of the
// frame peak finder so they travel as one bundle.
//
// Signals:
//   local_init_done    controller calibration done
//   local_rdata        LANES samples of DW bits, lane i at [i*DW +: DW]
//   local_rdata_valid  read data valid
//   frame_restart      synchronous frame abort/clear
//   peak_data          peak value of the last completed frame
//   peak_addr          sample address of that peak
//   peak_valid         one-cycle pulse when the frame result is updated
//   frame_count        completed frames, wraps at 0xFFFF
//   sample_addr        address of lane 0 of the next accepted beat
//
// Modports:
//   master  drives the beat stream, observes the results
//   slave   the peak finder itself
// ---------------------------------------------------------------------------
interface peak_find_frame_if #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int AW    = 16
);
  logic                  local_init_done;
  logic [DW*LANES-1:0]   local_rdata;
  logic                  local_rdata_valid;
  logic                  frame_restart;
  logic [DW-1:0]         peak_data;
  logic [AW-1:0]         peak_addr;
  logic                  peak_valid;
  logic [15:0]           frame_count;
  logic [AW-1:0]         sample_addr;

  modport master (
    output local_init_done, local_rdata, local_rdata_valid, frame_restart,
    input  peak_data, peak_addr, peak_valid, frame_count, sample_addr
  );

  modport slave (
    input  local_init_done, local_rdata, local_rdata_valid, frame_restart,
    output peak_data, peak_addr, peak_valid, frame_count, sample_addr
  );
endinterface

// File: rtl/peak_find_frame.sv
// ---------------------------------------------------------------------------
// peak_find_frame
// Frame peak finder on the DDR2 read path. Every accepted beat carries LANES
// samples; a registered pairwise max tree reduces each beat to its largest
// sample, and an accumulator stage tracks the frame maximum and its sample
// address. When the last beat of a FRAME_LEN-sample frame leaves the tree,
// the result is published with a one-cycle peak_valid pulse.
//
// Ports:
//   phy_clk          clock
//   reset_phy_clk_n  asynchronous active-low reset
//   bus              peak_find_frame_if.slave (beat stream in, results out)
//
// Latency: a beat accepted on edge k is in stage 0 after k, in tree level j
// after k+j, and reaches the accumulator on edge k+L+1 (L = log2(LANES)).
// ---------------------------------------------------------------------------
module peak_find_frame #(
  parameter int DW         = 16,
  parameter int LANES      = 4,
  parameter int FRAME_LEN  = 4000,
  parameter int AW         = 16,
  parameter int SIGNED     = 0,
  parameter int SKIP_FIRST = 1
) (
  input  logic            phy_clk,
  input  logic            reset_phy_clk_n,
  peak_find_frame_if.slave bus
);

  localparam int L     = $clog2(LANES);
  localparam int NODES = 2 * LANES - 1;
  localparam int ROOT  = NODES - 1;
  localparam logic [AW:0] LANES_X = (AW + 1)'(LANES);
  localparam logic [AW:0] FRAME_X = (AW + 1)'(FRAME_LEN);

  // Tree nodes are packed level after level into one array: level 0 holds
  // the LANES leaves, level j holds LANES>>j nodes, the root is last.
  function automatic int levelBase(input int j);
    return 2 * LANES - ((2 * LANES) >> j);
  endfunction

  // Strictly-greater compare; ties keep the incumbent, which is always the
  // lower address (lower lane in the tree, earlier beat in the accumulator).
  function automatic logic isGreater(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic [DW-1:0] nodeData_q [NODES];
  logic [DW-1:0] nodeData_d [NODES];
  logic [AW-1:0] nodeAddr_q [NODES];
  logic [AW-1:0] nodeAddr_d [NODES];
  logic [L:0]    stageVld_q, stageVld_d;
  logic [L:0]    stageLast_q, stageLast_d;

  logic [AW-1:0] sampleAddr_q, sampleAddr_d;
  logic          skipDone_q, skipDone_d;

  logic          accEmpty_q, accEmpty_d;
  logic [DW-1:0] accData_q, accData_d;
  logic [AW-1:0] accAddr_q, accAddr_d;

  logic [DW-1:0] peakData_q, peakData_d;
  logic [AW-1:0] peakAddr_q, peakAddr_d;
  logic          peakValid_q, peakValid_d;
  logic [15:0]   frameCount_q, frameCount_d;

  logic          accept;
  logic          takeBeat;
  logic          lastBeat;
  logic [AW:0]   nextAddr;
  logic          outVld;
  logic          takeRoot;
  logic [DW-1:0] newData;
  logic [AW-1:0] newAddr;

  // Beat qualification and frame addressing. The very first accepted beat
  // after reset is calibration readback when SKIP_FIRST is set: it only
  // sets the skip flag and never advances the address or enters the tree.
  // A restart zeroes the address and wins over a simultaneous beat.
  always_comb begin
    accept       = bus.local_rdata_valid && bus.local_init_done && !bus.frame_restart;
    takeBeat     = accept && ((SKIP_FIRST == 0) || skipDone_q);
    nextAddr     = {1'b0, sampleAddr_q} + LANES_X;
    lastBeat     = (nextAddr == FRAME_X);
    skipDone_d   = skipDone_q;
    sampleAddr_d = sampleAddr_q;
    if (bus.frame_restart) begin
      sampleAddr_d = '0;
    end else if (accept && !takeBeat) begin
      skipDone_d = 1'b1;
    end else if (takeBeat) begin
      sampleAddr_d = lastBeat ? '0 : nextAddr[AW-1:0];
    end
  end

  // Stage 0 captures the raw lanes with their addresses every cycle; the
  // valid tag decides whether a slot is a real beat or a bubble. Each tree
  // level then keeps the larger of each lane pair, moving the valid and
  // last tags along with the data. A restart kills every tag in flight.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      nodeData_d[i] = nodeData_q[i];
      nodeAddr_d[i] = nodeAddr_q[i];
    end
    for (int i = 0; i < LANES; i++) begin
      nodeData_d[i] = bus.local_rdata[i*DW +: DW];
      nodeAddr_d[i] = sampleAddr_q + AW'(i);
    end
    for (int j = 1; j <= L; j++) begin
      for (int n = 0; n < (LANES >> j); n++) begin
        if (isGreater(nodeData_q[levelBase(j-1) + 2*n + 1], nodeData_q[levelBase(j-1) + 2*n])) begin
          nodeData_d[levelBase(j) + n] = nodeData_q[levelBase(j-1) + 2*n + 1];
          nodeAddr_d[levelBase(j) + n] = nodeAddr_q[levelBase(j-1) + 2*n + 1];
        end else begin
          nodeData_d[levelBase(j) + n] = nodeData_q[levelBase(j-1) + 2*n];
          nodeAddr_d[levelBase(j) + n] = nodeAddr_q[levelBase(j-1) + 2*n];
        end
      end
    end
    stageVld_d     = '0;
    stageLast_d    = '0;
    stageVld_d[0]  = takeBeat;
    stageLast_d[0] = takeBeat && lastBeat;
    for (int j = 1; j <= L; j++) begin
      stageVld_d[j]  = stageVld_q[j-1] && !bus.frame_restart;
      stageLast_d[j] = stageLast_q[j-1];
    end
  end

  // Accumulator and result stage. An empty accumulator loads the root
  // unconditionally; otherwise the root replaces it only when strictly
  // greater. The last beat of a frame publishes the combined maximum and
  // leaves the accumulator empty, so the next frame's first beat can load
  // on the very next edge with no bubble. A restart empties it without
  // publishing, and the published outputs hold.
  always_comb begin
    outVld       = stageVld_q[L] && !bus.frame_restart;
    takeRoot     = accEmpty_q || isGreater(nodeData_q[ROOT], accData_q);
    newData      = takeRoot ? nodeData_q[ROOT] : accData_q;
    newAddr      = takeRoot ? nodeAddr_q[ROOT] : accAddr_q;
    accEmpty_d   = accEmpty_q;
    accData_d    = accData_q;
    accAddr_d    = accAddr_q;
    peakData_d   = peakData_q;
    peakAddr_d   = peakAddr_q;
    peakValid_d  = 1'b0;
    frameCount_d = frameCount_q;
    if (bus.frame_restart) begin
      accEmpty_d = 1'b1;
    end else if (outVld) begin
      if (stageLast_q[L]) begin
        peakData_d   = newData;
        peakAddr_d   = newAddr;
        peakValid_d  = 1'b1;
        frameCount_d = frameCount_q + 16'd1;
        accEmpty_d   = 1'b1;
      end else begin
        accData_d  = newData;
        accAddr_d  = newAddr;
        accEmpty_d = 1'b0;
      end
    end
  end

  // All state registers; reset returns the block to an empty frame at
  // address 0 with cleared outputs and the skip flag armed again.
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      for (int i = 0; i < NODES; i++) begin
        nodeData_q[i] <= '0;
        nodeAddr_q[i] <= '0;
      end
      stageVld_q   <= '0;
      stageLast_q  <= '0;
      sampleAddr_q <= '0;
      skipDone_q   <= 1'b0;
      accEmpty_q   <= 1'b1;
      accData_q    <= '0;
      accAddr_q    <= '0;
      peakData_q   <= '0;
      peakAddr_q   <= '0;
      peakValid_q  <= 1'b0;
      frameCount_q <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) begin
        nodeData_q[i] <= nodeData_d[i];
        nodeAddr_q[i] <= nodeAddr_d[i];
      end
      stageVld_q   <= stageVld_d;
      stageLast_q  <= stageLast_d;
      sampleAddr_q <= sampleAddr_d;
      skipDone_q   <= skipDone_d;
      accEmpty_q   <= accEmpty_d;
      accData_q    <= accData_d;
      accAddr_q    <= accAddr_d;
      peakData_q   <= peakData_d;
      peakAddr_q   <= peakAddr_d;
      peakValid_q  <= peakValid_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign bus.peak_data   = peakData_q;
  assign bus.peak_addr   = peakAddr_q;
  assign bus.peak_valid  = peakValid_q;
  assign bus.frame_count = frameCount_q;
  assign bus.sample_addr = sampleAddr_q;

endmodule

// File: tb/tb_peak_find_frame.sv
// ---------------------------------------------------------------------------
// tb_peak_find_frame
// Drives one shared beat stream into three peak finders (FRAME_LEN=16,
// LANES=4, DW=16): unsigned/no-skip (U), signed/no-skip (S) and
// unsigned/skip-first (K). U and S share reset rstA; K has its own reset
// rstK and is only released for the skip scenario. Expected frame results
// are queued when the last beat of a frame is driven and popped when the
// matching DUT pulses peak_valid.
// ---------------------------------------------------------------------------
module tb_peak_find_frame;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int FL    = 16;
  localparam int AW    = 16;

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    logic [15:0] count;
    int          edgeNum;
  } expT;

  logic        clk = 1'b0;
  logic        rstA;
  logic        rstK;
  logic [63:0] rdata;
  logic        rvalid;
  logic        initDone;
  logic        restart;

  expT         qU[$];
  expT         qS[$];
  expT         qK[$];
  expT         monE;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          cntA = 0;
  int          cntK = 0;
  logic [15:0] smp [16];

  always #5 clk = ~clk;

  // Posedge counter used to check the exact result latency.
  always @(posedge clk) cyc <= cyc + 1;

  peak_find_frame_if #(.DW(DW), .LANES(LANES), .AW(AW)) ifU (), ifS (), ifK ();

  assign ifU.local_init_done = initDone;
  assign ifU.local_rdata = rdata;
  assign ifU.local_rdata_valid = rvalid;
  assign ifU.frame_restart = restart;
  assign ifS.local_init_done = initDone;
  assign ifS.local_rdata = rdata;
  assign ifS.local_rdata_valid = rvalid;
  assign ifS.frame_restart = restart;
  assign ifK.local_init_done = initDone;
  assign ifK.local_rdata = rdata;
  assign ifK.local_rdata_valid = rvalid;
  assign ifK.frame_restart = restart;

  peak_find_frame #(.DW(DW), .LANES(LANES), .FRAME_LEN(FL), .AW(AW), .SIGNED(0), .SKIP_FIRST(0))
    uU (.phy_clk(clk), .reset_phy_clk_n(rstA), .bus(ifU.slave));
  peak_find_frame #(.DW(DW), .LANES(LANES), .FRAME_LEN(FL), .AW(AW), .SIGNED(1), .SKIP_FIRST(0))
    uS (.phy_clk(clk), .reset_phy_clk_n(rstA), .bus(ifS.slave));
  peak_find_frame #(.DW(DW), .LANES(LANES), .FRAME_LEN(FL), .AW(AW), .SIGNED(0), .SKIP_FIRST(1))
    uK (.phy_clk(clk), .reset_phy_clk_n(rstK), .bus(ifK.slave));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic comparePulse(input string tag, input expT e, input logic [15:0] d,
                              input logic [15:0] a, input logic [15:0] c);
    checkOutput({tag, " peak_data"}, 32'(d), 32'(e.data));
    checkOutput({tag, " peak_addr"}, 32'(a), 32'(e.addr));
    checkOutput({tag, " frame_count"}, 32'(c), 32'(e.count));
    checkOutput({tag, " latency edge"}, cyc, e.edgeNum);
  endtask

  // Drive one cycle of inputs on the falling edge; the next rising edge
  // samples them.
  task automatic applyStimulus(input logic [63:0] d, input logic v, input logic init, input logic rst);
    @(negedge clk);
    rdata    = d;
    rvalid   = v;
    initDone = init;
    restart  = rst;
  endtask

  task automatic sendBeat(input int b);
    applyStimulus({smp[4*b+3], smp[4*b+2], smp[4*b+1], smp[4*b]}, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic sendFrame();
    for (int b = 0; b < 4; b++) sendBeat(b);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(64'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fillSamples(input logic [15:0] v);
    for (int i = 0; i < 16; i++) smp[i] = v;
  endtask

  // Called right after the last beat of a frame is driven: it is accepted
  // on edge cyc+1 and its result appears on edge cyc+4.
  task automatic pushA(input logic [15:0] dU, input logic [15:0] aU,
                       input logic [15:0] dS, input logic [15:0] aS);
    expT e;
    cntA++;
    e.count   = cntA[15:0];
    e.edgeNum = cyc + 4;
    e.data    = dU;
    e.addr    = aU;
    qU.push_back(e);
    e.data    = dS;
    e.addr    = aS;
    qS.push_back(e);
  endtask

  task automatic pushK(input logic [15:0] d, input logic [15:0] a);
    expT e;
    cntK++;
    e.count   = cntK[15:0];
    e.edgeNum = cyc + 4;
    e.data    = d;
    e.addr    = a;
    qK.push_back(e);
  endtask

  // Output monitor: every peak_valid pulse must match the oldest queued
  // expectation for that DUT; a pulse with nothing queued is a failure.
  always @(negedge clk) begin
    if (ifU.peak_valid) begin
      if (qU.size() == 0) checkOutput("U unexpected peak_valid", 32'(ifU.peak_valid), 32'd0);
      else begin
        monE = qU.pop_front();
        comparePulse("U", monE, ifU.peak_data, ifU.peak_addr, ifU.frame_count);
      end
    end
    if (ifS.peak_valid) begin
      if (qS.size() == 0) checkOutput("S unexpected peak_valid", 32'(ifS.peak_valid), 32'd0);
      else begin
        monE = qS.pop_front();
        comparePulse("S", monE, ifS.peak_data, ifS.peak_addr, ifS.frame_count);
      end
    end
    if (ifK.peak_valid) begin
      if (qK.size() == 0) checkOutput("K unexpected peak_valid", 32'(ifK.peak_valid), 32'd0);
      else begin
        monE = qK.pop_front();
        comparePulse("K", monE, ifK.peak_data, ifK.peak_addr, ifK.frame_count);
      end
    end
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstA = 1'b0;
    rstK = 1'b0;
    rdata = '0;
    rvalid = 1'b0;
    initDone = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset U peak_data", 32'(ifU.peak_data), 32'h0);
    checkOutput("reset U peak_addr", 32'(ifU.peak_addr), 32'h0);
    checkOutput("reset U peak_valid", 32'(ifU.peak_valid), 32'h0);
    checkOutput("reset U frame_count", 32'(ifU.frame_count), 32'h0);
    checkOutput("reset U sample_addr", 32'(ifU.sample_addr), 32'h0);
    checkOutput("reset K frame_count", 32'(ifK.frame_count), 32'h0);
    rstA = 1'b1;
    idle(2);

    // Ramp frame: sample value equals its address
    $display("[TB] ramp frame");
    for (int a = 0; a < 16; a++) smp[a] = 16'(a);
    sendFrame();
    pushA(16'd15, 16'd15, 16'd15, 16'd15);
    idle(7);
    checkOutput("hold U peak_data", 32'(ifU.peak_data), 32'd15);
    checkOutput("hold U frame_count", 32'(ifU.frame_count), 32'd1);
    checkOutput("hold U peak_valid low", 32'(ifU.peak_valid), 32'd0);
    checkOutput("wrap U sample_addr", 32'(ifU.sample_addr), 32'd0);

    // Ties resolve to the lowest address
    $display("[TB] tie frames");
    fillSamples(16'h0100);
    sendFrame();
    pushA(16'h0100, 16'd0, 16'h0100, 16'd0);
    idle(6);
    fillSamples(16'h0000);
    smp[6]  = 16'h0100;
    smp[13] = 16'h0100;
    sendFrame();
    pushA(16'h0100, 16'd6, 16'h0100, 16'd6);
    idle(6);

    // Signed versus unsigned compare
    $display("[TB] signed frame");
    fillSamples(16'h0000);
    smp[3] = 16'h7FFF;
    smp[7] = 16'h8000;
    sendFrame();
    pushA(16'h8000, 16'd7, 16'h7FFF, 16'd3);
    idle(6);

    // Restart together with the third beat of a frame
    $display("[TB] restart frame");
    fillSamples(16'h0F00);
    sendBeat(0);
    sendBeat(1);
    applyStimulus({smp[11], smp[10], smp[9], smp[8]}, 1'b1, 1'b1, 1'b1);
    checkOutput("pre-restart U sample_addr", 32'(ifU.sample_addr), 32'd8);
    idle(1);
    checkOutput("post-restart U sample_addr", 32'(ifU.sample_addr), 32'd0);
    idle(4);
    fillSamples(16'h0011);
    smp[9] = 16'h0033;
    sendFrame();
    pushA(16'h0033, 16'd9, 16'h0033, 16'd9);
    idle(6);

    // Back-to-back frames, then asynchronous reset mid-frame
    $display("[TB] back-to-back frames");
    fillSamples(16'h0010);
    smp[2] = 16'h0900;
    sendFrame();
    pushA(16'h0900, 16'd2, 16'h0900, 16'd2);
    fillSamples(16'h0001);
    smp[14] = 16'h0050;
    sendFrame();
    pushA(16'h0050, 16'd14, 16'h0050, 16'd14);
    idle(6);
    fillSamples(16'h0007);
    sendBeat(0);
    sendBeat(1);
    #2 rstA = 1'b0;
    #1;
    checkOutput("async U peak_data", 32'(ifU.peak_data), 32'h0);
    checkOutput("async U peak_addr", 32'(ifU.peak_addr), 32'h0);
    checkOutput("async U frame_count", 32'(ifU.frame_count), 32'h0);
    checkOutput("async U sample_addr", 32'(ifU.sample_addr), 32'h0);
    checkOutput("async S frame_count", 32'(ifS.frame_count), 32'h0);
    cntA = 0;
    idle(2);

    // Skip-first DUT: calibration beat, gaps and init_done dropout
    $display("[TB] skip-first frame");
    rstK = 1'b1;
    idle(2);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    idle(1);
    checkOutput("skip K sample_addr", 32'(ifK.sample_addr), 32'd0);
    for (int a = 0; a < 16; a++) smp[a] = 16'(a + 1);
    for (int b = 0; b < 4; b++) begin
      sendBeat(b);
      if (b == 3) begin
        pushK(16'd16, 16'd15);
      end else begin
        idle(int'($urandom_range(1, 3)));
        if (b == 1) begin
          applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
          applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
          checkOutput("init-low K sample_addr", 32'(ifK.sample_addr), 32'd8);
        end
      end
    end
    idle(8);
    checkOutput("hold K frame_count", 32'(ifK.frame_count), 32'd1);

    // Every queued result must have been produced
    checkOutput("U pending results", 32'(qU.size()), 32'd0);
    checkOutput("S pending results", 32'(qS.size()), 32'd0);
    checkOutput("K pending results", 32'(qK.size()), 32'd0);

    $display("[TB] stimulus complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_find_frame.md
Name: peak_find_frame

Overview:
- Parametrised frame peak finder on the DDR2 controller read path, clocked by phy_clk.
- Each accepted read beat carries LANES samples of DW bits. A pipelined reduction tree finds the per-beat maximum; a running accumulator tracks the frame maximum and its sample address.
- At the end of each FRAME_LEN-sample frame the block emits the peak value and its address with a one-cycle valid pulse.
- Generalises the fixed 4x16-bit comparator: lane count, width, frame length, signed mode, tie rule, explicit frame-done handshake and restart.

Parameters:
- DW, 16, sample width in bits.
- LANES, 4, samples per beat; power of two, at least 2.
- FRAME_LEN, 4000, samples per frame; must be a multiple of LANES.
- AW, 16, sample address width; 2^AW must be at least FRAME_LEN.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- SKIP_FIRST, 1, 1 = discard the first accepted beat after reset (calibration readback).

Ports:
- phy_clk  in  1  clock.
- reset_phy_clk_n  in  1  asynchronous active-low reset.
- local_init_done  in  1  controller calibration done.
- local_rdata  in  DW*LANES  read data; lane i occupies bits [i*DW +: DW].
- local_rdata_valid  in  1  read data valid.
- frame_restart  in  1  synchronous frame abort/clear.
- peak_data  out  DW  peak value of the last completed frame.
- peak_addr  out  AW  sample address of that peak.
- peak_valid  out  1  one-cycle pulse, frame result updated.
- frame_count  out  16  completed frames, wraps at 0xFFFF -> 0.
- sample_addr  out  AW  address of lane 0 of the next accepted beat.

Behaviour:
- Reset clears all outputs, the pipeline valid tags, the accumulator and the skip flag. Reset may assert at any time; on release the block starts a fresh frame at address 0.
- Beat accept: acc = local_rdata_valid && local_init_done && !frame_restart. With SKIP_FIRST=1, the first acc after reset sets the skip flag and is dropped: no address advance, no compare.
- Addressing:
  - Lane i of a beat has address sample_addr + i.
  - sample_addr += LANES per accepted beat.
  - When sample_addr + LANES == FRAME_LEN, that beat is tagged last and sample_addr wraps to 0.
- Pipeline, L = log2(LANES):
  - Edge k: stage 0 registers the samples, addresses, valid and last tag.
  - Edges k+1..k+L: registered pairwise max tree stages.
  - Edge k+L+1: accumulator/output stage.
  - Invalid slots are bubbles and never alter results.
- Compare rule:
  - Signed or unsigned per SIGNED.
  - Replace only if strictly greater, so ties resolve to the lower address, both in the tree (lower lane wins) and in the accumulator (earlier beat wins).
- Accumulator:
  - Empty flag set at frame start.
  - First valid beat of a frame loads unconditionally; later beats compare against the stored maximum.
- Frame end: when the last-tagged beat reaches the output stage (edge k+L+1 after its accept edge k):
  - peak_data/peak_addr take the final maximum, including that beat.
  - peak_valid is high for exactly one cycle.
  - frame_count increments.
  - The accumulator returns to empty.
- peak_data, peak_addr and frame_count hold between pulses.
- frame_restart, synchronous:
  - Sets sample_addr to 0, clears all pipeline valid tags and empties the accumulator.
  - No peak_valid is produced for the aborted frame.
  - peak_* outputs and frame_count hold.
  - If asserted in the same cycle as a valid beat, restart wins and the beat is lost.
- local_init_done low: beats ignored; state holds.
- Back-to-back frames with no bubble are supported. The first beat of frame n+1 loads the accumulator in the same cycle that frame n's result is emitted.

Test Plan:
1. LANES=4, DW=16, FRAME_LEN=16, SIGNED=0, SKIP_FIRST=0; 4 consecutive beats, sample at address a = a -> peak_data=15, peak_addr=15, single peak_valid 3 cycles after the last beat's accept edge, frame_count=1.
2. All 16 samples 0x0100 -> peak_addr=0 (lowest-address tie rule); repeat with 0x0100 only at addresses 6 and 13 (others 0) -> peak_addr=6.
3. 0x7FFF at address 3, 0x8000 at address 7, others 0: SIGNED=1 -> peak_data=0x7FFF, peak_addr=3; SIGNED=0 -> peak_data=0x8000, peak_addr=7.
4. SKIP_FIRST=1: first beat after reset is all 0xFFFF, then frame 1..16 delivered with random 1-3 cycle valid gaps and local_init_done low for 2 cycles mid-frame -> 0xFFFF ignored, peak_data=16, peak_addr=15.
5. frame_restart asserted together with the third valid beat of a frame -> no peak_valid; next beat has sample_addr=0; the following full frame reports only its own peak; frame_count unchanged by the abort.
6. Two back-to-back frames, frame 1 max 0x0900 at address 2, frame 2 max 0x0050 at address 14 -> peak_valid pulses report (0x0900, 2) then (0x0050, 14); frame_count goes 1 then 2; async reset mid-frame 3 -> all outputs 0 immediately.
